// File: rtl/ub_pkg.sv
// ub_pkg: shared types and width helpers for the banked unified buffer
package ub_pkg;
  typedef enum logic [1:0] {UB_COMPUTE, UB_FIFO, UB_STORE, UB_RSVD} ub_mode_t;
  typedef enum logic {IDLE, BURST} ub_state_t;
  function automatic int w1(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  function automatic int lanes(input int a);
    return a * a;
  endfunction
endpackage

// File: rtl/ub_bank.sv
// ub_bank: single-port bank, synchronous read, bit write mask, registered output
module ub_bank
  import ub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 64,
  localparam int AW = w1(DEPTH)
)(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             we,
  input  logic [AW-1:0]    row,
  input  logic [WIDTH-1:0] wdata,
  input  logic [WIDTH-1:0] wmask,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (en && we) mem[row] <= (mem[row] & ~wmask) | (wdata & wmask);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rdata <= '0;
    else if (en && !we) rdata <= mem[row];
endmodule

// File: rtl/banked_unified_buffer.sv
// banked_unified_buffer: banked scratchpad shared by compute, FIFO and store clients
module banked_unified_buffer
  import ub_pkg::*;
#(
  parameter int BUFFER_SIZE = 1024,
  parameter int BUFFER_WORD_SIZE = 16,
  parameter int FIFO_DATA_WIDTH = 8,
  parameter int COMPUTE_DATA_WIDTH = 4,
  parameter int ARRAY_SIZE = 8,
  parameter int NUM_COMPUTE_LANES = lanes(ARRAY_SIZE),
  parameter int STORE_DATA_WIDTH = 16,
  parameter int MAX_BURST = 16,
  parameter int ADDRESS_SIZE = $clog2(BUFFER_SIZE),
  localparam int ITEMS = BUFFER_WORD_SIZE / COMPUTE_DATA_WIDTH,
  localparam int BANKS = NUM_COMPUTE_LANES / ITEMS,
  localparam int SLICES = BUFFER_WORD_SIZE / FIFO_DATA_WIDTH,
  localparam int LEN_W = $clog2(MAX_BURST),
  localparam int SEC_W = w1(SLICES),
  localparam int ROWS = BUFFER_SIZE / BANKS,
  localparam int ROW_W = w1(ROWS),
  localparam int BANK_W = w1(BANKS),
  localparam int W = BUFFER_WORD_SIZE,
  localparam int CW = NUM_COMPUTE_LANES * COMPUTE_DATA_WIDTH
)(
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic                        req_write,
  input  logic [1:0]                  req_mode,
  input  logic [ADDRESS_SIZE-1:0]     req_addr,
  input  logic [LEN_W-1:0]            req_len,
  input  logic [ADDRESS_SIZE-1:0]     req_stride,
  input  logic [SEC_W-1:0]            req_section,
  input  logic [FIFO_DATA_WIDTH-1:0]  fifo_in,
  input  logic [STORE_DATA_WIDTH-1:0] store_in,
  input  logic signed [CW-1:0]        compute_in,
  output logic                        beat,
  output logic                        rsp_valid,
  output logic [FIFO_DATA_WIDTH-1:0]  fifo_out,
  output logic [STORE_DATA_WIDTH-1:0] store_out,
  output logic signed [CW-1:0]        compute_out,
  output logic                        done,
  output logic                        err
);
  ub_state_t state, state_n;
  ub_mode_t mode_q, cur_mode, rsp_mode;
  logic write_q, cur_write, accept, single, last, rd;
  logic [ADDRESS_SIZE-1:0] addr_q, stride_q, cur_addr, cur_stride, next_addr;
  logic [ADDRESS_SIZE:0] sum;
  logic [LEN_W-1:0] left_q;
  logic [SEC_W-1:0] sec_q, cur_sec, rsp_sec;
  logic [BANK_W-1:0] lo, rsp_lo;
  logic [ROW_W-1:0] hi_row, hi_row1;
  logic [W-1:0] bank_rd [BANKS];
  logic [W-1:0] sel_rd;
  logic [CW-1:0] xbar, compute_hold;
  logic [FIFO_DATA_WIDTH-1:0] fifo_hold;
  logic [STORE_DATA_WIDTH-1:0] store_hold;
  // beat 0 runs straight from the request inputs; later beats from latched fields
  always_comb begin
    req_ready = state == IDLE;
    accept = req_valid && req_ready && rst_n;
    beat = accept || state == BURST;
    cur_mode = accept ? ub_mode_t'(req_mode) : mode_q;
    cur_write = accept ? req_write : write_q;
    cur_addr = accept ? req_addr : addr_q;
    cur_stride = accept ? req_stride : stride_q;
    cur_sec = accept ? req_section : sec_q;
    single = req_len == '0 || cur_mode == UB_RSVD;
    last = state == BURST && left_q == LEN_W'(1);
    state_n = accept && !single ? BURST : last ? IDLE : state;
    rd = beat && !cur_write && cur_mode != UB_RSVD;
    sum = {1'b0, cur_addr} + {1'b0, cur_stride};
    next_addr = sum >= (ADDRESS_SIZE+1)'(BUFFER_SIZE) ? ADDRESS_SIZE'(sum - (ADDRESS_SIZE+1)'(BUFFER_SIZE)) : ADDRESS_SIZE'(sum);
    lo = BANK_W'(cur_addr % ADDRESS_SIZE'(BANKS));
    hi_row = ROW_W'(cur_addr / ADDRESS_SIZE'(BANKS));
    hi_row1 = hi_row == ROW_W'(ROWS - 1) ? '0 : hi_row + ROW_W'(1);
    sel_rd = bank_rd[rsp_lo];
    xbar = '0;
    for (int j = 0; j < BANKS; j++) xbar[j*W +: W] = bank_rd[(int'(rsp_lo) + j) % BANKS];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      done <= 1'b0;
      err <= 1'b0;
      rsp_valid <= 1'b0;
      mode_q <= UB_COMPUTE;
      write_q <= 1'b0;
      addr_q <= '0;
      stride_q <= '0;
      sec_q <= '0;
      left_q <= '0;
      rsp_mode <= UB_COMPUTE;
      rsp_lo <= '0;
      rsp_sec <= '0;
      compute_hold <= '0;
      fifo_hold <= '0;
      store_hold <= '0;
    end else begin
      state <= state_n;
      done <= (accept && single) || last;
      err <= accept && cur_mode == UB_RSVD;
      rsp_valid <= rd;
      if (beat) begin
        mode_q <= cur_mode;
        write_q <= cur_write;
        addr_q <= next_addr;
        stride_q <= cur_stride;
        sec_q <= cur_sec;
        left_q <= accept ? req_len : left_q - LEN_W'(1);
      end
      if (rd) begin
        rsp_mode <= cur_mode;
        rsp_lo <= lo;
        rsp_sec <= cur_sec;
      end
      compute_hold <= compute_out;
      fifo_hold <= fifo_out;
      store_hold <= store_out;
    end
  // unselected client outputs keep showing their last response
  assign compute_out = rsp_valid && rsp_mode == UB_COMPUTE ? xbar : compute_hold;
  assign fifo_out = rsp_valid && rsp_mode == UB_FIFO ? sel_rd[int'(rsp_sec)*FIFO_DATA_WIDTH +: FIFO_DATA_WIDTH] : fifo_hold;
  assign store_out = rsp_valid && rsp_mode == UB_STORE ? sel_rd[STORE_DATA_WIDTH-1:0] : store_hold;
  // a compute beat rotates its BANKS words across banks starting at bank lo
  for (genvar i = 0; i < BANKS; i++) begin : g_bank
    logic [BANK_W-1:0] j;
    logic [ROW_W-1:0] row;
    logic en;
    logic [W-1:0] wdata, wmask;
    always_comb begin
      j = BANK_W'((i + BANKS - int'(lo)) % BANKS);
      row = BANK_W'(i) >= lo ? hi_row : hi_row1;
      en = beat && (cur_mode == UB_COMPUTE || (cur_mode != UB_RSVD && BANK_W'(i) == lo));
      wdata = cur_mode == UB_COMPUTE ? compute_in[int'(j)*W +: W]
            : cur_mode == UB_FIFO ? {SLICES{fifo_in}} : W'(store_in);
      wmask = cur_mode == UB_COMPUTE ? '1
            : cur_mode == UB_FIFO ? W'({FIFO_DATA_WIDTH{1'b1}}) << (int'(cur_sec) * FIFO_DATA_WIDTH)
            : W'({STORE_DATA_WIDTH{1'b1}});
    end
    ub_bank #(.WIDTH(W), .DEPTH(ROWS)) u_bank (
      .clk(clk), .rst_n(rst_n), .en(en), .we(cur_write), .row(row),
      .wdata(wdata), .wmask(wmask), .rdata(bank_rd[i])
    );
  end
endmodule

// File: tb/tb_banked_unified_buffer.sv
// tb_banked_unified_buffer: directed self-checking bench for banked_unified_buffer
module tb_banked_unified_buffer;
  logic clk = 0, rst_n = 0;
  logic req_valid = 0, req_ready, req_write = 0;
  logic [1:0] req_mode = 0;
  logic [9:0] req_addr = 0, req_stride = 0;
  logic [3:0] req_len = 0;
  logic req_section = 0;
  logic [7:0] fifo_in = 0, fifo_out;
  logic [15:0] store_in = 0, store_out;
  logic [255:0] compute_in = '0, compute_out, exp_v;
  logic beat, rsp_valid, done, err;
  int errors = 0, checks = 0;
  int nb, nr, nd;
  logic [15:0] vals [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};

  always #5 clk = ~clk;

  banked_unified_buffer dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_mode(req_mode), .req_addr(req_addr), .req_len(req_len),
    .req_stride(req_stride), .req_section(req_section), .fifo_in(fifo_in),
    .store_in(store_in), .compute_in(compute_in), .beat(beat), .rsp_valid(rsp_valid),
    .fifo_out(fifo_out), .store_out(store_out), .compute_out(compute_out),
    .done(done), .err(err)
  );

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input logic w, input logic [1:0] m, input logic [9:0] a,
                         input logic [3:0] l, input logic [9:0] s, input logic sec);
    req_write = w; req_mode = m; req_addr = a; req_len = l; req_stride = s;
    req_section = sec; req_valid = 1;
  endtask

  task automatic single(input logic w, input logic [1:0] m, input logic [9:0] a, input logic sec);
    @(negedge clk); set_req(w, m, a, 0, 0, sec);
    @(negedge clk); req_valid = 0;
  endtask

  task automatic st_rd(input logic [9:0] a, input logic [15:0] e, input string tag);
    single(0, 2, a, 0);
    chk(tag, 256'(store_out), 256'(e));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk); @(negedge clk);
    chk("rst_ready", 256'(req_ready), 256'(1));
    chk("rst_beat", 256'(beat), 256'(0));
    chk("rst_outs", 256'({rsp_valid, done, err}), 256'(0));
    chk("rst_data", compute_out | 256'({fifo_out, store_out}), 256'(0));
    rst_n = 1;

    for (int k = 0; k < 64; k++) compute_in[k*4 +: 4] = 4'(k % 8);
    single(1, 0, 0, 0);
    chk("cw_done", 256'(done), 256'(1));
    @(negedge clk); set_req(0, 0, 0, 0, 0, 0);
    #1;
    chk("cr_beat", 256'(beat), 256'(1));
    chk("cr_rsp_early", 256'(rsp_valid), 256'(0));
    @(negedge clk); req_valid = 0;
    chk("cr_rsp", 256'(rsp_valid), 256'(1));
    chk("cr_data", compute_out, {8{32'h76543210}});
    chk("cr_done", 256'(done), 256'(1));
    @(negedge clk);
    chk("cr_rsp_once", 256'(rsp_valid), 256'(0));

    store_in = 16'h1234; single(1, 2, 14, 0);
    compute_in = '1; single(1, 0, 1022, 0);
    st_rd(1022, 16'hFFFF, "wrap_1022");
    st_rd(1023, 16'hFFFF, "wrap_1023");
    st_rd(0, 16'hFFFF, "wrap_0");
    st_rd(13, 16'hFFFF, "wrap_13");
    st_rd(14, 16'h1234, "wrap_14_kept");
    single(0, 0, 1022, 0);
    chk("wrap_cread", compute_out, '1);

    for (int j = 0; j < 16; j++) compute_in[j*16 +: 16] = 16'hA000 + 16'(j);
    single(1, 0, 32, 0);
    for (int j = 0; j < 16; j++) compute_in[j*16 +: 16] = 16'hB000 + 16'(j);
    single(1, 0, 48, 0);
    for (int j = 0; j < 16; j++) exp_v[j*16 +: 16] = j < 8 ? 16'hA008 + 16'(j) : 16'hB000 + 16'(j - 8);
    single(0, 0, 40, 0);
    chk("rot_cread", compute_out, exp_v);

    @(negedge clk); set_req(1, 2, 10, 3, 5, 0); store_in = vals[0];
    nb = 0; nr = 0; nd = 0;
    for (int c = 0; c < 7; c++) begin
      #1;
      nb += int'(beat); nr += int'(!req_ready); nd += int'(done);
      @(negedge clk); req_valid = 0; store_in = vals[(c + 1) % 4];
    end
    chk("burst_beats", 256'(nb), 256'(4));
    chk("burst_notready", 256'(nr), 256'(3));
    chk("burst_done", 256'(nd), 256'(1));
    st_rd(10, 16'h1111, "burst_w10");
    st_rd(15, 16'h2222, "burst_w15");
    st_rd(20, 16'h3333, "burst_w20");
    st_rd(25, 16'h4444, "burst_w25");

    store_in = 16'hABCD; single(1, 2, 7, 0);
    fifo_in = 8'h5A; single(1, 1, 7, 1);
    st_rd(7, 16'h5ACD, "merge_store");
    single(0, 1, 7, 0);
    chk("merge_fifo0", 256'(fifo_out), 256'(8'hCD));
    chk("merge_store_hold", 256'(store_out), 256'(16'h5ACD));
    single(0, 1, 7, 1);
    chk("merge_fifo1", 256'(fifo_out), 256'(8'h5A));

    @(negedge clk); set_req(0, 2, 10, 0, 0, 0);
    #1;
    chk("b2b_first", 256'({req_ready, beat}), 256'(2'b11));
    @(negedge clk); req_addr = 15;
    #1;
    chk("b2b_second", 256'({req_ready, beat}), 256'(2'b11));
    chk("b2b_rsp1", 256'({rsp_valid, done, store_out}), 256'({2'b11, 16'h1111}));
    @(negedge clk); req_valid = 0;
    chk("b2b_rsp2", 256'({rsp_valid, done, store_out}), 256'({2'b11, 16'h2222}));

    store_in = 16'h0000; fifo_in = 8'h00; compute_in = '0;
    single(1, 3, 7, 0);
    chk("rsvd_pulse", 256'({err, done, rsp_valid}), 256'(3'b110));
    @(negedge clk);
    chk("rsvd_err_once", 256'(err), 256'(0));
    st_rd(7, 16'h5ACD, "rsvd_nochange");

    single(1, 0, 96, 0);
    @(negedge clk); set_req(1, 2, 100, 7, 1, 0); store_in = 16'hC000;
    @(negedge clk); req_valid = 0; store_in = 16'hC001;
    @(negedge clk); store_in = 16'hC002;
    #2 rst_n = 0;
    #1;
    chk("abort_ready", 256'({req_ready, beat}), 256'(2'b10));
    chk("abort_outs", 256'({rsp_valid, done, err}), 256'(0));
    chk("abort_data", compute_out | 256'({fifo_out, store_out}), 256'(0));
    @(negedge clk); rst_n = 1;
    nd = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk); nd += int'(done);
    end
    chk("abort_no_done", 256'(nd), 256'(0));
    st_rd(100, 16'hC000, "abort_w100");
    st_rd(101, 16'hC001, "abort_w101");
    st_rd(102, 16'h0000, "abort_w102");
    st_rd(107, 16'h0000, "abort_w107");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
